// File: rtl/pong_pixel_renderer_pkg.sv
// Shared Pong/VGA package: 640x480@60 timing, object geometry, colour codes
// and small geometry helpers used by the renderer and the colour splitter.
package vga_pong_pkg;

  localparam int CLK_DIV  = 4;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int PADDLE_W   = 8;
  localparam int PADDLE_H   = 64;
  localparam int BALL_SIZE  = 8;
  localparam int PADDLE_L_X = 16;
  localparam int PADDLE_R_X = 616;

  // Centre net: four pixels wide, dashed in 16-line segments
  localparam int NET_X0 = 318;
  localparam int NET_W  = 4;

  typedef enum logic [2:0] {
    COL_BG     = 3'b000,
    COL_PADDLE = 3'b010,
    COL_BALL   = 3'b110,
    COL_NET    = 3'b111
  } color_e;

  // True when start <= pos < start+len; 11 bits leave headroom so no wrap
  function automatic logic inSpan(input logic [10:0] pos,
                                  input logic [10:0] start,
                                  input logic [10:0] len);
    return (pos >= start) && (pos < start + len);
  endfunction

  // Limits a position so the object stays fully on screen
  function automatic logic [10:0] clampPos(input logic [10:0] pos,
                                           input logic [10:0] maxPos);
    return (pos > maxPos) ? maxPos : pos;
  endfunction

endpackage

// File: rtl/pong_pixel_renderer_if.sv
// Renderer bus: object positions in, pixel stream and sync out.
// The master drives positions (game logic / bench), the slave is the renderer.
interface pong_pixel_renderer_if;
  logic [8:0] i_paddle_l_y;
  logic [8:0] i_paddle_r_y;
  logic [9:0] i_ball_x;
  logic [8:0] i_ball_y;
  logic       o_pixel_refresh;
  logic [2:0] o_color;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_frame_start;

  modport master (
    output i_paddle_l_y, i_paddle_r_y, i_ball_x, i_ball_y,
    input  o_pixel_refresh, o_color, o_hsync, o_vsync, o_frame_start
  );

  modport slave (
    input  i_paddle_l_y, i_paddle_r_y, i_ball_x, i_ball_y,
    output o_pixel_refresh, o_color, o_hsync, o_vsync, o_frame_start
  );
endinterface

// File: rtl/pong_pixel_renderer_timing.sv
// VGA raster timing: pixel-clock divider, h/v counters and the combinational
// sync/active decode for the pixel currently addressed by the counters.
module vga_timing_counter #(
  parameter int CLK_DIV  = vga_pong_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pong_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pong_pkg::H_FP,
  parameter int H_SYNC   = vga_pong_pkg::H_SYNC,
  parameter int H_BP     = vga_pong_pkg::H_BP,
  parameter int V_ACTIVE = vga_pong_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pong_pkg::V_FP,
  parameter int V_SYNC   = vga_pong_pkg::V_SYNC,
  parameter int V_BP     = vga_pong_pkg::V_BP
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  output logic       o_tick,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_active,
  output logic       o_last_pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;

  assign o_tick = (r_div == DIV_W'(CLK_DIV - 1));

  // Divider free-runs; the raster position advances once per pixel tick
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= o_tick ? '0 : r_div + DIV_W'(1);
      if (o_tick) begin
        if (r_h == 10'(H_TOTAL - 1)) begin
          r_h <= '0;
          r_v <= (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  assign o_h          = r_h;
  assign o_v          = r_v;
  assign o_hsync_n    = !((r_h >= 10'(H_ACTIVE + H_FP)) &&
                          (r_h <= 10'(H_ACTIVE + H_FP + H_SYNC - 1)));
  assign o_vsync_n    = !((r_v >= 10'(V_ACTIVE + V_FP)) &&
                          (r_v <= 10'(V_ACTIVE + V_FP + V_SYNC - 1)));
  assign o_active     = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
  assign o_last_pixel = (r_h == 10'(H_TOTAL - 1)) && (r_v == 10'(V_TOTAL - 1));

endmodule

// File: rtl/pong_pixel_renderer.sv
// Pong scene renderer: snapshots object positions once per frame, tests the
// current pixel against ball, paddles and net, and registers colour and sync
// together so they always describe the same pixel.
module pong_pixel_renderer
  import vga_pong_pkg::*;
#(
  parameter int CLK_DIV_P    = CLK_DIV,
  parameter int H_ACTIVE_P   = H_ACTIVE,
  parameter int H_FP_P       = H_FP,
  parameter int H_SYNC_P     = H_SYNC,
  parameter int H_BP_P       = H_BP,
  parameter int V_ACTIVE_P   = V_ACTIVE,
  parameter int V_FP_P       = V_FP,
  parameter int V_SYNC_P     = V_SYNC,
  parameter int V_BP_P       = V_BP,
  parameter int PADDLE_W_P   = PADDLE_W,
  parameter int PADDLE_H_P   = PADDLE_H,
  parameter int BALL_SIZE_P  = BALL_SIZE,
  parameter int PADDLE_L_X_P = PADDLE_L_X,
  parameter int PADDLE_R_X_P = PADDLE_R_X,
  parameter int NET_X0_P     = NET_X0,
  parameter int NET_W_P      = NET_W
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  pong_pixel_renderer_if.slave  bus
);

  // Clamp limits keep objects fully visible; reset positions centre them
  localparam logic [10:0] PAD_Y_MAX  = 11'(V_ACTIVE_P - PADDLE_H_P);
  localparam logic [10:0] BALL_X_MAX = 11'(H_ACTIVE_P - BALL_SIZE_P);
  localparam logic [10:0] BALL_Y_MAX = 11'(V_ACTIVE_P - BALL_SIZE_P);
  localparam logic [8:0]  PAD_Y_RST  = 9'((V_ACTIVE_P - PADDLE_H_P) / 2);
  localparam logic [9:0]  BALL_X_RST = 10'((H_ACTIVE_P - BALL_SIZE_P) / 2);
  localparam logic [8:0]  BALL_Y_RST = 9'((V_ACTIVE_P - BALL_SIZE_P) / 2);

  logic        w_tick;
  logic [9:0]  w_h;
  logic [9:0]  w_v;
  logic        w_hsync_n;
  logic        w_vsync_n;
  logic        w_active;
  logic        w_last_pixel;
  logic [10:0] w_h11;
  logic [10:0] w_v11;
  logic        w_ball;
  logic        w_paddle;
  logic        w_net;
  logic [2:0]  w_color;

  logic [8:0]  r_pad_l_y;
  logic [8:0]  r_pad_r_y;
  logic [9:0]  r_ball_x;
  logic [8:0]  r_ball_y;
  logic        r_refresh;
  logic [2:0]  r_color;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  vga_timing_counter #(
    .CLK_DIV (CLK_DIV_P),
    .H_ACTIVE(H_ACTIVE_P), .H_FP(H_FP_P), .H_SYNC(H_SYNC_P), .H_BP(H_BP_P),
    .V_ACTIVE(V_ACTIVE_P), .V_FP(V_FP_P), .V_SYNC(V_SYNC_P), .V_BP(V_BP_P)
  ) u_timing (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .o_tick      (w_tick),
    .o_h         (w_h),
    .o_v         (w_v),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n),
    .o_active    (w_active),
    .o_last_pixel(w_last_pixel)
  );

  // Latch clamped positions on the very last pixel so a whole frame sees one set
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_pad_l_y <= PAD_Y_RST;
      r_pad_r_y <= PAD_Y_RST;
      r_ball_x  <= BALL_X_RST;
      r_ball_y  <= BALL_Y_RST;
    end else if (w_tick && w_last_pixel) begin
      r_pad_l_y <= 9'(clampPos(11'(bus.i_paddle_l_y), PAD_Y_MAX));
      r_pad_r_y <= 9'(clampPos(11'(bus.i_paddle_r_y), PAD_Y_MAX));
      r_ball_x  <= 10'(clampPos(11'(bus.i_ball_x), BALL_X_MAX));
      r_ball_y  <= 9'(clampPos(11'(bus.i_ball_y), BALL_Y_MAX));
    end
  end

  assign w_h11 = {1'b0, w_h};
  assign w_v11 = {1'b0, w_v};

  assign w_ball   = inSpan(w_h11, {1'b0, r_ball_x}, 11'(BALL_SIZE_P)) &&
                    inSpan(w_v11, {2'b0, r_ball_y}, 11'(BALL_SIZE_P));
  assign w_paddle = (inSpan(w_h11, 11'(PADDLE_L_X_P), 11'(PADDLE_W_P)) &&
                     inSpan(w_v11, {2'b0, r_pad_l_y}, 11'(PADDLE_H_P))) ||
                    (inSpan(w_h11, 11'(PADDLE_R_X_P), 11'(PADDLE_W_P)) &&
                     inSpan(w_v11, {2'b0, r_pad_r_y}, 11'(PADDLE_H_P)));
  assign w_net    = inSpan(w_h11, 11'(NET_X0_P), 11'(NET_W_P)) && !w_v[4];

  // Priority mux: ball over paddle over net over background, black in blanking
  always_comb begin
    w_color = 3'b000;
    if (w_active) begin
      if (w_ball)        w_color = COL_BALL;
      else if (w_paddle) w_color = COL_PADDLE;
      else if (w_net)    w_color = COL_NET;
      else               w_color = COL_BG;
    end
  end

  // Output registers load once per pixel; strobe trails the tick by one clock
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_refresh     <= 1'b0;
      r_color       <= 3'b000;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_refresh     <= w_tick;
      r_frame_start <= w_tick && (w_h == 10'd0) && (w_v == 10'd0);
      if (w_tick) begin
        r_color <= w_color;
        r_hsync <= w_hsync_n;
        r_vsync <= w_vsync_n;
      end
    end
  end

  assign bus.o_pixel_refresh = r_refresh;
  assign bus.o_color         = r_color;
  assign bus.o_hsync         = r_hsync;
  assign bus.o_vsync         = r_vsync;
  assign bus.o_frame_start   = r_frame_start;

endmodule

// File: tb/tb_pong_pixel_renderer.sv
// Directed bench for pong_pixel_renderer on a shrunken raster (80x40 total,
// 64x32 active, 4 clocks per pixel) so several whole frames fit in a short run.
module tb_pong_pixel_renderer;

  localparam int CLK_DIV = 4;
  localparam int HT      = 80;
  localparam int VT      = 40;
  localparam int FRAME   = HT * VT;

  localparam int C_BG   = 0;
  localparam int C_PAD  = 2;
  localparam int C_BALL = 6;
  localparam int C_NET  = 7;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int checkCount = 0;
  int passCount  = 0;
  int strobeIdx  = -1;
  int lastGap    = 0;
  int gapBad     = 0;
  int fsCount    = 0;
  int fsBad      = 0;
  int hBad       = 0;
  int vBad       = 0;
  int blankBad   = 0;
  int hLowLine0  = 0;
  int hFirstLow  = -1;
  bit statsOn    = 1'b1;

  pong_pixel_renderer_if bus();

  pong_pixel_renderer #(
    .CLK_DIV_P(CLK_DIV),
    .H_ACTIVE_P(64), .H_FP_P(4), .H_SYNC_P(8), .H_BP_P(4),
    .V_ACTIVE_P(32), .V_FP_P(2), .V_SYNC_P(2), .V_BP_P(4),
    .PADDLE_W_P(4), .PADDLE_H_P(16), .BALL_SIZE_P(4),
    .PADDLE_L_X_P(4), .PADDLE_R_X_P(56),
    .NET_X0_P(30), .NET_W_P(4)
  ) dut (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .bus      (bus.slave)
  );

  // 100 MHz system clock
  always #5 clock = ~clock;

  // Hard stop in case the bench itself wedges
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic finishRun();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  endtask

  // Advance to the next pixel strobe and gather per-pixel statistics
  task automatic stepStrobe();
    int waited = 0;
    int h, v;
    do begin
      @(negedge clock);
      waited++;
    end while (!bus.o_pixel_refresh && waited < 2 * CLK_DIV);
    if (!bus.o_pixel_refresh) begin
      checkOutput("strobe_timeout", 0, 1);
      finishRun();
      return;
    end
    lastGap = waited;
    if (waited != CLK_DIV) gapBad++;
    strobeIdx++;
    h = strobeIdx % HT;
    v = (strobeIdx / HT) % VT;
    if (bus.o_frame_start) begin
      fsCount++;
      if (strobeIdx % FRAME != 0) fsBad++;
    end else if (strobeIdx % FRAME == 0) begin
      fsBad++;
    end
    if (statsOn && strobeIdx < FRAME) begin
      if ((!bus.o_hsync) != (h >= 68 && h <= 75)) hBad++;
      if ((!bus.o_vsync) != (v >= 34 && v <= 35)) vBad++;
      if ((h >= 64 || v >= 32) && bus.o_color != 3'b000) blankBad++;
      if (v == 0 && !bus.o_hsync) begin
        hLowLine0++;
        if (hFirstLow < 0) hFirstLow = h;
      end
    end
  endtask

  task automatic gotoPixel(input int frame, input int h, input int v);
    int target = frame * FRAME + v * HT + h;
    while (strobeIdx < target) stepStrobe();
  endtask

  task automatic applyStimulus(input int padL, input int padR, input int bx, input int by);
    bus.i_paddle_l_y = 9'(padL);
    bus.i_paddle_r_y = 9'(padR);
    bus.i_ball_x     = 10'(bx);
    bus.i_ball_y     = 9'(by);
  endtask

  task automatic pixelIs(input string tag, input int frame, input int h, input int v,
                         input int expColor);
    gotoPixel(frame, h, v);
    checkOutput(tag, int'(bus.o_color), expColor);
  endtask

  initial begin
    applyStimulus(5, 100, 20, 10);

    // Held in reset: quiet outputs
    repeat (5) @(negedge clock);
    checkOutput("rst_refresh", int'(bus.o_pixel_refresh), 0);
    checkOutput("rst_color", int'(bus.o_color), 0);
    checkOutput("rst_hsync", int'(bus.o_hsync), 1);
    checkOutput("rst_vsync", int'(bus.o_vsync), 1);
    checkOutput("rst_frame_start", int'(bus.o_frame_start), 0);

    // Release; first strobe four clocks later is pixel (0,0)
    reset_n = 1'b1;
    stepStrobe();
    checkOutput("first_strobe_cycles", lastGap, 4);
    checkOutput("f0_frame_start", int'(bus.o_frame_start), 1);
    checkOutput("f0_px0_0", int'(bus.o_color), C_BG);

    // Frame 0 shows reset positions: paddles y=8, ball (30,14)
    pixelIs("f0_padL_4_8",   0,  4,  8, C_PAD);
    pixelIs("f0_net_31_13",  0, 31, 13, C_NET);
    pixelIs("f0_ball_30_14", 0, 30, 14, C_BALL);
    pixelIs("f0_ball_33_17", 0, 33, 17, C_BALL);
    pixelIs("f0_padR_59_23", 0, 59, 23, C_PAD);
    pixelIs("f0_bg_59_24",   0, 59, 24, C_BG);

    // Frame 1: ball (20,10), left paddle 5, right paddle 100 clamps to 16
    gotoPixel(1, 0, 2);
    applyStimulus(5, 100, 4, 5);
    pixelIs("f1_padL_4_5",    1,  4,  5, C_PAD);
    pixelIs("f1_ball_20_10",  1, 20, 10, C_BALL);
    pixelIs("f1_bg_24_10",    1, 24, 10, C_BG);
    pixelIs("f1_blank_70_10", 1, 70, 10, 0);
    pixelIs("f1_ball_23_13",  1, 23, 13, C_BALL);
    pixelIs("f1_bg_20_14",    1, 20, 14, C_BG);
    pixelIs("f1_bg_56_15",    1, 56, 15, C_BG);
    pixelIs("f1_netgap_31_16",1, 31, 16, C_BG);
    pixelIs("f1_padR_56_16",  1, 56, 16, C_PAD);
    pixelIs("f1_padL_4_20",   1,  4, 20, C_PAD);
    pixelIs("f1_bg_4_21",     1,  4, 21, C_BG);
    pixelIs("f1_padR_59_31",  1, 59, 31, C_PAD);
    pixelIs("f1_blank_31_33", 1, 31, 33, 0);

    // Frame 2: ball moved onto the left paddle; ball wins the overlap
    pixelIs("f2_net_31_0",    2, 31,  0, C_NET);
    pixelIs("f2_ball_4_5",    2,  4,  5, C_BALL);
    pixelIs("f2_bg_8_5",      2,  8,  5, C_BG);
    pixelIs("f2_ball_7_8",    2,  7,  8, C_BALL);
    pixelIs("f2_padL_4_9",    2,  4,  9, C_PAD);
    pixelIs("f2_bg_20_10",    2, 20, 10, C_BG);
    pixelIs("f2_padL_5_12",   2,  5, 12, C_PAD);

    // One-clock reset mid-frame
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("midrst_refresh", int'(bus.o_pixel_refresh), 0);
    checkOutput("midrst_color", int'(bus.o_color), 0);
    reset_n   = 1'b1;
    strobeIdx = -1;
    statsOn   = 1'b0;
    stepStrobe();
    checkOutput("midrst_latency", lastGap, 4);
    checkOutput("midrst_frame_start", int'(bus.o_frame_start), 1);
    pixelIs("midrst_ball_30_14", 0, 30, 14, C_BALL);
    gotoPixel(1, 0, 0);
    checkOutput("midrst_next_frame_start", int'(bus.o_frame_start), 1);

    // Whole-run statistics
    checkOutput("strobe_gaps_bad", gapBad, 0);
    checkOutput("frame_start_misplaced", fsBad, 0);
    checkOutput("frame_start_count", fsCount, 5);
    checkOutput("hsync_pattern_bad", hBad, 0);
    checkOutput("hsync_low_line0", hLowLine0, 8);
    checkOutput("hsync_first_low_h", hFirstLow, 68);
    checkOutput("vsync_pattern_bad", vBad, 0);
    checkOutput("blank_color_bad", blankBad, 0);

    finishRun();
  end

endmodule
